// File: rtl/dcf77_encoder.sv
// DCF77 minute-frame transmitter: BCD time fields in, pulse-width-coded tx out on the 10 ms tick.
// Optional macro DCF77_ENC_TZ_EN adds a cest input that drives the Z1/Z2 time-zone bits.
module dcf77_encoder #(
  parameter int TICKS_PER_SEC = 100,
  parameter int TICKS_ZERO    = 10,
  parameter int TICKS_ONE     = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       time_valid,
  output logic       time_ready,
  input  logic [6:0] minute,
  input  logic [5:0] hour,
  input  logic [5:0] day,
  input  logic [2:0] day_of_week,
  input  logic [4:0] month,
  input  logic [7:0] year,
`ifdef DCF77_ENC_TZ_EN
  input  logic       cest,
`endif
  output logic       tx,
  output logic [5:0] second,
  output logic       frame_start,
  output logic       underrun
);

  localparam int              TW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0]   TICK_LAST  = TW'(TICKS_PER_SEC - 1);
  localparam logic [TW-1:0]   W_ZERO     = TW'(TICKS_ZERO);
  localparam logic [TW-1:0]   W_ONE      = TW'(TICKS_ONE);
  localparam logic [58:0]     FRAME_RST  = 59'h140000;

  function automatic logic even_parity(input logic [31:0] v);
    return ^v;
  endfunction

  function automatic logic [58:0] build_frame(
    input logic [6:0] mi, input logic [5:0] hr, input logic [5:0] dy,
    input logic [2:0] dw, input logic [4:0] mo, input logic [7:0] yr,
    input logic       z1, input logic       z2
  );
    logic [58:0] f;
    f        = {59{1'b0}};
    f[17]    = z1;
    f[18]    = z2;
    f[20]    = 1'b1;
    f[27:21] = mi;
    f[28]    = even_parity({25'd0, mi});
    f[34:29] = hr;
    f[35]    = even_parity({26'd0, hr});
    f[41:36] = dy;
    f[44:42] = dw;
    f[49:45] = mo;
    f[57:50] = yr;
    f[58]    = even_parity({10'd0, yr, mo, dw, dy});
    return f;
  endfunction

  logic [TW-1:0] tick_r;
  logic [5:0]    second_r;
  logic          tx_r;
  logic          time_ready_r;
  logic          frame_start_r;
  logic          underrun_r;
  logic [58:0]   frame_r;

  logic          z1_s;
  logic          z2_s;
  logic [58:0]   frame_new_s;
  logic          accept_s;
  logic          wrap_tick_s;
  logic          wrap_min_s;
  logic [TW-1:0] tick_next_s;
  logic [5:0]    second_next_s;
  logic [63:0]   frame_pad_s;
  logic          bit_s;
  logic [TW-1:0] width_s;
  logic          tx_next_s;

`ifdef DCF77_ENC_TZ_EN
  assign z1_s = cest;
  assign z2_s = ~cest;
`else
  assign z1_s = 1'b0;
  assign z2_s = 1'b1;
`endif

  assign frame_new_s = build_frame(minute, hour, day, day_of_week, month, year, z1_s, z2_s);
  assign accept_s    = time_valid && time_ready_r;

  // Next tick/second position and the pulse level for the tick being entered.
  always_comb begin
    wrap_tick_s = (tick_r == TICK_LAST);
    if (wrap_tick_s) begin
      tick_next_s = {TW{1'b0}};
      if (second_r == 6'd59) begin
        second_next_s = 6'd0;
      end else begin
        second_next_s = second_r + 6'd1;
      end
    end else begin
      tick_next_s   = tick_r + TW'(1);
      second_next_s = second_r;
    end
    wrap_min_s  = clk_en && wrap_tick_s && (second_r == 6'd59);
    frame_pad_s = {5'd0, frame_r};
    bit_s       = frame_pad_s[second_next_s];
    if (bit_s) begin
      width_s = W_ONE;
    end else begin
      width_s = W_ZERO;
    end
    tx_next_s = (second_next_s != 6'd59) && (tick_next_s < width_s);
  end

  // Timebase, handshake, shadow frame and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_r        <= {TW{1'b0}};
      second_r      <= 6'd59;
      tx_r          <= 1'b0;
      time_ready_r  <= 1'b1;
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
      frame_r       <= FRAME_RST;
    end else begin
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
      if (accept_s) begin
        frame_r      <= frame_new_s;
        time_ready_r <= 1'b0;
      end
      if (clk_en) begin
        tick_r   <= tick_next_s;
        second_r <= second_next_s;
        tx_r     <= tx_next_s;
        if (wrap_tick_s && (second_r == 6'd58)) begin
          time_ready_r <= 1'b1;
        end
        // Closing the minute without a handshake reuses the old frame and flags it.
        if (wrap_min_s) begin
          frame_start_r <= 1'b1;
          underrun_r    <= time_ready_r && !time_valid;
          time_ready_r  <= 1'b0;
        end
      end
    end
  end

  assign tx          = tx_r;
  assign second      = second_r;
  assign time_ready  = time_ready_r;
  assign frame_start = frame_start_r;
  assign underrun    = underrun_r;

endmodule

// File: tb/tb_dcf77_encoder.sv
// Scoreboard bench for dcf77_encoder: expected frames are queued at accept time and
// compared against frames decoded from tx pulse widths.
module tb_dcf77_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b0;
  logic       time_valid = 1'b0;
  logic       time_ready;
  logic [6:0] minute = 7'h00;
  logic [5:0] hour = 6'h00;
  logic [5:0] day = 6'h00;
  logic [2:0] day_of_week = 3'd0;
  logic [4:0] month = 5'h00;
  logic [7:0] year = 8'h00;
  logic       tx;
  logic [5:0] second;
  logic       frame_start;
  logic       underrun;

  int n_cmp = 0;
  int n_err = 0;
  bit en_run = 1'b0;

  logic [58:0] exp_q[$];
  logic [58:0] last_exp;
  int          widths[59];
  logic [58:0] cap_bits;
  logic        cap_underrun;
  logic        cap_rise_ok;
  bit          cap_ok;

  dcf77_encoder dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .time_valid(time_valid),
    .time_ready(time_ready), .minute(minute), .hour(hour), .day(day),
    .day_of_week(day_of_week), .month(month), .year(year), .tx(tx),
    .second(second), .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Irregular tick: about three clk_en pulses in four clocks, changed just after posedge.
  initial forever begin
    @(posedge clk);
    #1;
    clk_en = en_run && ($urandom_range(0, 3) != 0);
  end

  function automatic logic [58:0] model_frame(
    input logic [6:0] mi, input logic [5:0] hr, input logic [5:0] dy,
    input logic [2:0] dw, input logic [4:0] mo, input logic [7:0] yr
  );
    logic [58:0] f;
    logic [21:0] date;
    f = 59'd0;
    f[18] = 1'b1;
    f[20] = 1'b1;
    for (int i = 0; i < 7; i++) f[21 + i] = mi[i];
    f[28] = (($countones(mi) % 2) == 1);
    for (int i = 0; i < 6; i++) f[29 + i] = hr[i];
    f[35] = (($countones(hr) % 2) == 1);
    for (int i = 0; i < 6; i++) f[36 + i] = dy[i];
    for (int i = 0; i < 3; i++) f[42 + i] = dw[i];
    for (int i = 0; i < 5; i++) f[45 + i] = mo[i];
    for (int i = 0; i < 8; i++) f[50 + i] = yr[i];
    date = {yr, mo, dw, dy};
    f[58] = (($countones(date) % 2) == 1);
    return f;
  endfunction

  task automatic capture_frame();
    int n;
    int w;
    logic pen;
    logic ptx;
    cap_ok = 1'b1;
    cap_bits = 59'd0;
    n = 0;
    pen = clk_en;
    ptx = tx;
    while (frame_start !== 1'b1 && n < 30000) begin
      pen = clk_en;
      ptx = tx;
      @(negedge clk);
      n++;
    end
    if (frame_start !== 1'b1) begin
      cap_ok = 1'b0;
      return;
    end
    cap_underrun = underrun;
    cap_rise_ok = (pen === 1'b1) && (ptx === 1'b0) && (tx === 1'b1);
    for (int b = 0; b < 59; b++) begin
      n = 0;
      while (tx !== 1'b1 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      w = 0;
      n = 0;
      while (tx === 1'b1 && n < 1000) begin
        if (clk_en === 1'b1) w++;
        @(negedge clk);
        n++;
      end
      widths[b] = w;
      cap_bits[b] = (w > 15);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL reset_tx: got %b expected 0", tx); end
    n_cmp++; if (second !== 6'd59) begin n_err++; $display("FAIL reset_second: got %0d expected 59", second); end
    n_cmp++; if (time_ready !== 1'b1) begin n_err++; $display("FAIL reset_time_ready: got %b expected 1", time_ready); end
    n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    rst_n = 1'b1;
    en_run = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_accept();
    logic [58:0] exp;
    minute = 7'h37; hour = 6'h13; day = 6'h15; day_of_week = 3'd6; month = 5'h06; year = 8'h24;
    time_valid = 1'b1;
    last_exp = model_frame(7'h37, 6'h13, 6'h15, 3'd6, 5'h06, 8'h24);
    exp_q.push_back(last_exp);
    @(negedge clk);
    // Garbage with valid held high mid-minute must be ignored.
    minute = 7'h7F; hour = 6'h3F; day = 6'h3F; day_of_week = 3'd0; month = 5'h1F; year = 8'hFF;
    n_cmp++; if (time_ready !== 1'b0) begin n_err++; $display("FAIL accept_ready_drop: got %b expected 0", time_ready); end
    capture_frame();
    time_valid = 1'b0;
    n_cmp++; if (!cap_ok) begin n_err++; $display("FAIL accept_frame_start_timeout: got none expected pulse"); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 59'd0;
    n_cmp++; if (cap_bits !== exp) begin n_err++; $display("FAIL accept_frame: got %h expected %h", cap_bits, exp); end
    n_cmp++; if (cap_bits[27:21] !== 7'h37) begin n_err++; $display("FAIL accept_minute_bits: got %h expected 37", cap_bits[27:21]); end
    n_cmp++; if (cap_bits[28] !== 1'b1) begin n_err++; $display("FAIL accept_p1: got %b expected 1", cap_bits[28]); end
    n_cmp++; if (cap_bits[35] !== 1'b1) begin n_err++; $display("FAIL accept_p2: got %b expected 1", cap_bits[35]); end
    n_cmp++; if (cap_bits[20] !== 1'b1) begin n_err++; $display("FAIL accept_s_bit: got %b expected 1", cap_bits[20]); end
    n_cmp++; if (cap_underrun !== 1'b0) begin n_err++; $display("FAIL accept_underrun: got %b expected 0", cap_underrun); end
  endtask

  task automatic test_pulse_width();
    n_cmp++; if (widths[0] != 10) begin n_err++; $display("FAIL width_bit0: got %0d expected 10", widths[0]); end
    n_cmp++; if (widths[20] != 20) begin n_err++; $display("FAIL width_bit20: got %0d expected 20", widths[20]); end
    n_cmp++; if (cap_rise_ok !== 1'b1) begin n_err++; $display("FAIL tx_rise_latency: got %b expected 1", cap_rise_ok); end
  endtask

  task automatic test_underrun();
    int n;
    int t;
    int hi;
    logic [58:0] exp;
    time_valid = 1'b0;
    exp_q.push_back(last_exp);
    n = 0;
    while (second !== 6'd59 && n < 5000) begin @(negedge clk); n++; end
    t = 0; hi = 0; n = 0;
    while (second === 6'd59 && n < 5000) begin
      if (clk_en === 1'b1) t++;
      if (tx === 1'b1) hi++;
      @(negedge clk);
      n++;
    end
    n_cmp++; if (t != 100) begin n_err++; $display("FAIL sec59_ticks: got %0d expected 100", t); end
    n_cmp++; if (hi != 0) begin n_err++; $display("FAIL sec59_tx_low: got %0d high samples expected 0", hi); end
    capture_frame();
    n_cmp++; if (!cap_ok) begin n_err++; $display("FAIL underrun_frame_start_timeout: got none expected pulse"); end
    n_cmp++; if (cap_underrun !== 1'b1) begin n_err++; $display("FAIL underrun_pulse: got %b expected 1", cap_underrun); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 59'd0;
    n_cmp++; if (cap_bits !== exp) begin n_err++; $display("FAIL underrun_repeat_frame: got %h expected %h", cap_bits, exp); end
  endtask

  task automatic test_last_clk_en();
    int n;
    int c;
    logic [58:0] exp;
    last_exp = model_frame(7'h59, 6'h23, 6'h31, 3'd7, 5'h12, 8'h99);
    exp_q.push_back(last_exp);
    n = 0;
    while (second !== 6'd59 && n < 5000) begin @(negedge clk); n++; end
    c = 0; n = 0;
    while (c < 100 && n < 5000) begin
      if (clk_en === 1'b1) c++;
      if (c < 100) begin @(negedge clk); n++; end
    end
    minute = 7'h59; hour = 6'h23; day = 6'h31; day_of_week = 3'd7; month = 5'h12; year = 8'h99;
    time_valid = 1'b1;
    n_cmp++; if (time_ready !== 1'b1) begin n_err++; $display("FAIL late_ready: got %b expected 1", time_ready); end
    @(negedge clk);
    time_valid = 1'b0;
    minute = 7'h00; hour = 6'h00; day = 6'h00; day_of_week = 3'd0; month = 5'h00; year = 8'h00;
    capture_frame();
    n_cmp++; if (!cap_ok) begin n_err++; $display("FAIL late_frame_start_timeout: got none expected pulse"); end
    n_cmp++; if (cap_underrun !== 1'b0) begin n_err++; $display("FAIL late_underrun: got %b expected 0", cap_underrun); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 59'd0;
    n_cmp++; if (cap_bits !== exp) begin n_err++; $display("FAIL late_frame: got %h expected %h", cap_bits, exp); end
  endtask

  task automatic test_reset_mid_pulse();
    int n;
    int c;
    n = 0;
    while (!(second === 6'd30 && tx === 1'b1) && n < 20000) begin @(negedge clk); n++; end
    c = 0; n = 0;
    while (c < 5 && n < 2000) begin
      if (clk_en === 1'b1) c++;
      @(negedge clk);
      n++;
    end
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL midpulse_tx_before: got %b expected 1", tx); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL midpulse_tx_async: got %b expected 0", tx); end
    n_cmp++; if (second !== 6'd59) begin n_err++; $display("FAIL midpulse_second: got %0d expected 59", second); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (second !== 6'd59) begin n_err++; $display("FAIL release_second: got %0d expected 59", second); end
    n_cmp++; if (time_ready !== 1'b1) begin n_err++; $display("FAIL release_time_ready: got %b expected 1", time_ready); end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_pulse_width();
    test_underrun();
    test_last_clk_en();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
